// File: rtl/gnrc_edge_gen.sv
// gnrc_edge_gen: rebuilds a level signal from rise/fall event strobes.
// After every output transition the level is held for at least HOLD_CYCLES cycles.
// While a hold is running, one opposite transition can be buffered.
// Events that cannot be honoured are reported on drop_o.
//
// Ports:
//   clk_i    clock, all logic on the rising edge
//   rst_i    synchronous active-high reset
//   r_i      rise event strobe (request q_o = 1)
//   f_i      fall event strobe (request q_o = 0)
//   q_o      regenerated level (registered)
//   trans_o  one-cycle pulse in the first cycle q_o shows a new value
//   busy_o   hold counter running or a transition pending
//   drop_o   one-cycle pulse in the cycle after an event was discarded
module gnrc_edge_gen #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1),
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic r_i,
    input  logic f_i,
    output logic q_o,
    output logic trans_o,
    output logic busy_o,
    output logic drop_o
);

    localparam logic [CNT_W-1:0] Reload = CNT_W'(HOLD_CYCLES - 1);

    logic             q_q, q_d;
    logic             trans_q, trans_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_level_q, pend_level_d;

    logic ev_legal;
    logic ev_illegal;
    logic target;
    logic eff_level;

    assign ev_legal   = r_i ^ f_i;
    assign ev_illegal = r_i & f_i;
    assign target     = r_i;
    // Level the output is heading to once any buffered transition has applied.
    assign eff_level  = pend_valid_q ? pend_level_q : q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q          <= INIT_LEVEL;
            trans_q      <= 1'b0;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_level_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            trans_q      <= trans_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_level_q <= pend_level_d;
        end
    end

    always_comb begin
        q_d          = q_q;
        trans_d      = 1'b0;
        drop_d       = 1'b0;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_level_d = pend_level_q;

        // Hold countdown, or apply the buffered transition once the hold expires.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (pend_valid_q) begin
            q_d          = pend_level_q;
            cnt_d        = Reload;
            trans_d      = 1'b1;
            pend_valid_d = 1'b0;
        end

        if (ev_illegal) begin
            drop_d = 1'b1;
        end else if (ev_legal && (target != eff_level)) begin
            if (cnt_q == '0) begin
                if (!pend_valid_q) begin
                    q_d     = target;
                    cnt_d   = Reload;
                    trans_d = 1'b1;
                end else begin
                    // Buffered transition applies above; this event takes its slot.
                    pend_valid_d = 1'b1;
                    pend_level_d = target;
                end
            end else if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_level_d = target;
            end else begin
                // Opposite of the buffered transition: the pulse pair collapses.
                pend_valid_d = 1'b0;
                drop_d       = 1'b1;
            end
        end
    end

    assign q_o     = q_q;
    assign trans_o = trans_q;
    assign drop_o  = drop_q;
    assign busy_o  = (cnt_q != '0) | pend_valid_q;

endmodule

// File: tb/tb_gnrc_edge_gen.sv
module tb_gnrc_edge_gen;

    logic clk = 1'b0;
    logic rst_i;
    logic r_i, f_i;
    logic q_o, trans_o, busy_o, drop_o;
    logic r1_i, f1_i;
    logic q1_o, trans1_o, busy1_o, drop1_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gnrc_edge_gen #(
        .HOLD_CYCLES(4),
        .INIT_LEVEL (1'b0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .r_i    (r_i),
        .f_i    (f_i),
        .q_o    (q_o),
        .trans_o(trans_o),
        .busy_o (busy_o),
        .drop_o (drop_o)
    );

    gnrc_edge_gen #(
        .HOLD_CYCLES(1),
        .INIT_LEVEL (1'b0)
    ) dut1 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .r_i    (r1_i),
        .f_i    (f1_i),
        .q_o    (q1_o),
        .trans_o(trans1_o),
        .busy_o (busy1_o),
        .drop_o (drop1_o)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check q, trans, busy, drop of the HOLD_CYCLES=4 instance.
    task automatic expect4(input string tag, input logic q, input logic t, input logic b,
                           input logic d);
        chk({tag, ".q"}, q_o, q);
        chk({tag, ".trans"}, trans_o, t);
        chk({tag, ".busy"}, busy_o, b);
        chk({tag, ".drop"}, drop_o, d);
    endtask

    // Present r/f for one cycle, then sample #1 after the edge that consumed them.
    task automatic step(input logic r, input logic f);
        r_i = r;
        f_i = f;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        f_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        r_i   = 1'b0;
        f_i   = 1'b0;
        r1_i  = 1'b0;
        f1_i  = 1'b0;

        // 1: reset held 3 cycles, then idle
        repeat (3) step(1'b0, 1'b0);
        expect4("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.q1", q1_o, 1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            expect4("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 2: rise, then fall buffered during hold
        step(1'b1, 1'b0); expect4("s2.c11", 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c12", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1); expect4("s2.c13", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c14", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c15", 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c16", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c17", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s2.c18", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: illegal r&f while idle
        step(1'b1, 1'b1); expect4("s3.c11", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0); expect4("s3.c12", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: rise, fall buffered, rise cancels the pending fall
        step(1'b1, 1'b0); expect4("s4.c11", 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s4.c12", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1); expect4("s4.c13", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0); expect4("s4.c14", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            expect4("s4.tail", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // 5: redundant rise while settled high
        step(1'b1, 1'b0); expect4("s5.redund", 1'b1, 1'b0, 1'b0, 1'b0);
        // back to low, let the hold expire
        step(1'b0, 1'b1); expect4("s5.fall", 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.h2", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.h1", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.h0", 1'b0, 1'b0, 1'b0, 1'b0);
        // rise, fall pending, redundant fall mid-hold
        step(1'b1, 1'b0); expect4("s5.rise", 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1); expect4("s5.pend", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1); expect4("s5.redf", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.cnt0", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.apply", 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.a2", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.a1", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s5.a0", 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: reset mid-hold with a pending fall
        step(1'b1, 1'b0); expect4("s6.c11", 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); expect4("s6.c12", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1); expect4("s6.c13", 1'b1, 1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        step(1'b0, 1'b0); expect4("s6.c14", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            expect4("s6.tail", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // HOLD_CYCLES=1: alternating rise/fall toggles q every cycle
        for (int i = 0; i < 8; i++) begin
            r1_i = (i % 2 == 0);
            f1_i = ~r1_i;
            @(posedge clk);
            #1;
            r1_i = 1'b0;
            f1_i = 1'b0;
            chk("h1.q", q1_o, (i % 2 == 0));
            chk("h1.trans", trans1_o, 1'b1);
            chk("h1.busy", busy1_o, 1'b0);
            chk("h1.drop", drop1_o, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
